mem_bus_master: RTL
===================

// Module: mem_bus_master
// PURPOSE
//   Bus initiator driving the byte-wide memory/IO bus (ce/w/r/oe strobes, addr, 8-bit data).
//   Accepts single read/write requests from the CPU core over a valid/ready handshake.
//   Sequences the bus strobes to the responder's timing: 1-cycle write, 2-cycle read.
//   Returns read data with a one-cycle rsp_valid pulse. One outstanding request at a time.
// PARAMETERS
//   ADDR_W  16  bus address width
//   DATA_W  8   bus data width; request/response data ports are 2*DATA_W wide
// PORTS
//   clk        in   1         clock, all logic on posedge
//   rst        in   1         reset, synchronous, active-high
//   req_valid  in   1         request present
//   req_ready  out  1         master idle; request accepted when req_valid & req_ready
//   req_write  in   1         1 = write, 0 = read
//   req_addr   in   ADDR_W    byte address
//   req_wdata  in   2*DATA_W  write data; low byte used unless word access
//   req_word   in   1         two-byte access (ignored without MEM_MASTER_WORD_EN)
//   rsp_valid  out  1         1-cycle pulse: request complete
//   rsp_rdata  out  2*DATA_W  read data, held until next read completes
//   busy       out  1         ~req_ready
//   mem_addr   out  ADDR_W    bus address
//   mem_wdata  out  DATA_W    bus write data
//   mem_rdata  in   DATA_W    bus read data (responder drives when ce&oe)
//   mem_ce, mem_w, mem_r, mem_oe  out  1 each  bus strobes
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1 after reset; rsp_valid=0, rsp_rdata=0, mem_* all 0.
//   - All mem_* outputs registered, decoded from state; w and r never both 1.
//   - States: IDLE, WR, RD_ADDR, RD_DATA (+ HI-byte variants with macro).
//   - IDLE: req_ready=1; on accept latch addr/wdata/write/word, go WR or RD_ADDR.
//   - WR: ce=1,w=1,addr,wdata for one cycle -> IDLE; rsp_valid pulses in the IDLE cycle.
//     Write latency: accept edge -> rsp_valid 1 cycle after WR cycle (2 edges).
//   - RD_ADDR: ce=1,r=1 (responder latches data_reg) -> RD_DATA.
//   - RD_DATA: ce=1,oe=1, same addr; at end of cycle capture mem_rdata into rsp_rdata[7:0]
//     (upper byte <= 0) -> IDLE with rsp_valid=1. Read latency: 3 edges accept->rsp_valid.
//   - mem_addr held constant through RD_ADDR/RD_DATA (responder region decode uses addr).
//   - Back-to-back: new request may be accepted in the cycle rsp_valid=1.
//   - req_valid while busy: ignored, no queueing; requester must hold until accepted.
//   - rst mid-transaction: next cycle all strobes 0, IDLE, no rsp_valid, rsp_rdata=0;
//     partial write of a word (low byte only) is not rolled back.
//   - Idle bus: addr/wdata hold last value, strobes 0.
// CONFIGURATION
//   MEM_MASTER_WORD_EN defined: req_word=1 performs two byte transfers, low byte at addr,
//     high byte at addr+1 (ADDR_W-bit wrap, 0xFFFF -> 0x0000), little-endian.
//     Word write: WR, WR_HI -> rsp_valid once (3 edges). Word read: RD_ADDR, RD_DATA,
//     RD_ADDR_HI, RD_DATA_HI -> single rsp_valid with {hi,lo} (5 edges).
//     Strobes deassert for 0 cycles between bytes; addr changes only at byte boundary.
//   Not defined: req_word ignored, every access is one byte; no HI states synthesized.
// TESTING
//   1. rst 2 cycles -> req_ready=1, rsp_valid=0, all mem_* strobes 0, rsp_rdata=0.
//   2. write 0x0012<=0xA5 -> one cycle ce=1,w=1,addr=0x0012,wdata=0xA5; rsp_valid next cycle.
//   3. read 0x0012 after test 2 with RAM model -> RD_ADDR(ce,r) then RD_DATA(ce,oe);
//      rsp_valid 3 edges after accept, rsp_rdata=0x00A5; w never 1.
//   4. write 0x8000<=0x3C then immediate read 0x8000 in rsp_valid cycle -> rsp_rdata=0x003C,
//      no idle cycle between transactions; IO-region addr stable across read.
//   5. assert rst during RD_ADDR -> next cycle strobes 0, req_ready=1, no rsp_valid pulse.
//   6. (WORD_EN) word write 0xFFFF<=0xBEEF -> bytes EF@0xFFFF, BE@0x0000; word read back
//      -> rsp_rdata=0xBEEF, single rsp_valid 5 edges after accept.

Source files
------------

// File: rtl/mem_bus_master.sv
// Byte-wide memory/IO bus initiator: registered strobes, 1-cycle write and 2-cycle read, one request in flight.
// Define MEM_MASTER_WORD_EN to add little-endian two-byte transfers (HI-byte states).
module mem_bus_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    input  logic                req_word_i,
    output logic                rsp_valid_o,
    output logic [2*DATA_W-1:0] rsp_rdata_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                mem_ce_o,
    output logic                mem_w_o,
    output logic                mem_r_o,
    output logic                mem_oe_o
);

    typedef enum logic [2:0] {
        IDLE, WR, RD_ADDR, RD_DATA
`ifdef MEM_MASTER_WORD_EN
        , WR_HI, RD_ADDR_HI, RD_DATA_HI
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                accept;
    logic                w_d, r_d, oe_d, ce_d, rsp_valid_d, hi_step;
    logic                ce_q, w_q, r_q, oe_q, rsp_valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [2*DATA_W-1:0] rsp_rdata_q;
`ifdef MEM_MASTER_WORD_EN
    logic                word_q;
    logic [DATA_W-1:0]   wdata_hi_q, rd_lo_q;
`else
    logic                unused_word;
    assign unused_word = ^{req_word_i, req_wdata_i[2*DATA_W-1:DATA_W]};
`endif

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = ~req_ready_o;
    assign accept      = req_valid_i & req_ready_o;

    always_comb begin
        state_d = state_q;
        w_d     = 1'b0;
        r_d     = 1'b0;
        oe_d    = 1'b0;
        hi_step = 1'b0;
        case (state_q)
            IDLE:       if (accept) state_d = req_write_i ? WR : RD_ADDR;
            RD_ADDR:    state_d = RD_DATA;
`ifdef MEM_MASTER_WORD_EN
            WR:         state_d = word_q ? WR_HI : IDLE;
            RD_DATA:    state_d = word_q ? RD_ADDR_HI : IDLE;
            WR_HI:      state_d = IDLE;
            RD_ADDR_HI: state_d = RD_DATA_HI;
            RD_DATA_HI: state_d = IDLE;
`else
            WR:         state_d = IDLE;
            RD_DATA:    state_d = IDLE;
`endif
            default:    state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they line up with state_q.
        case (state_d)
            WR:         w_d  = 1'b1;
            RD_ADDR:    r_d  = 1'b1;
            RD_DATA:    oe_d = 1'b1;
`ifdef MEM_MASTER_WORD_EN
            WR_HI:      w_d  = 1'b1;
            RD_ADDR_HI: r_d  = 1'b1;
            RD_DATA_HI: oe_d = 1'b1;
`endif
            default:    ;
        endcase
        ce_d        = w_d | r_d | oe_d;
        rsp_valid_d = (state_q != IDLE) && (state_d == IDLE);
`ifdef MEM_MASTER_WORD_EN
        hi_step = ((state_q == WR) && (state_d == WR_HI)) ||
                  ((state_q == RD_DATA) && (state_d == RD_ADDR_HI));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ce_q        <= 1'b0;
            w_q         <= 1'b0;
            r_q         <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ce_q        <= ce_d;
            w_q         <= w_d;
            r_q         <= r_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i[DATA_W-1:0];
            end else if (hi_step) begin
                addr_q  <= addr_q + ADDR_W'(1);
`ifdef MEM_MASTER_WORD_EN
                wdata_q <= wdata_hi_q;
`endif
            end
            if ((state_q == RD_DATA) && (state_d == IDLE))
                rsp_rdata_q <= {{DATA_W{1'b0}}, mem_rdata_i};
`ifdef MEM_MASTER_WORD_EN
            if (state_q == RD_DATA_HI)
                rsp_rdata_q <= {mem_rdata_i, rd_lo_q};
`endif
        end
    end

`ifdef MEM_MASTER_WORD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= 1'b0;
            wdata_hi_q <= '0;
            rd_lo_q    <= '0;
        end else begin
            if (accept) begin
                word_q     <= req_word_i;
                wdata_hi_q <= req_wdata_i[2*DATA_W-1:DATA_W];
            end
            // Low byte is parked here so rsp_rdata only changes once per word read.
            if (state_q == RD_DATA)
                rd_lo_q <= mem_rdata_i;
        end
    end
`endif

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_ce_o    = ce_q;
    assign mem_w_o     = w_q;
    assign mem_r_o     = r_q;
    assign mem_oe_o    = oe_q;

endmodule
